div_ctrl: RTL
=============

# div_ctrl

- Sequencer for the iterative 32-bit divider behind DIV/DIVU.
- Accepts a start request from EX and latches the operands.
- Runs one restoring trial-subtraction step per cycle under a four-state FSM, then returns {remainder, quotient} for the HI/LO write path.
- EX holds its stall request while `start_i` is high and `ready_o` is low; `annul_i` (flush) aborts an operation in flight.

## Interface
Parameters:
- None.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, synchronous, active-high
- `signed_div_i`  in  1  1 = DIV (signed), 0 = DIVU
- `opdata1_i`  in  32  dividend
- `opdata2_i`  in  32  divisor
- `start_i`  in  1  request; held high by EX until `ready_o` seen
- `annul_i`  in  1  abort current/pending operation
- `result_o`  out  64  {remainder[63:32], quotient[31:0]}, registered
- `ready_o`  out  1  result valid, registered

## Operation
FSM states: FREE, BYZERO, ON, END.

- **FREE**
  - If `start_i`=1 and `annul_i`=0, latch the operands and `signed_div_i`.
  - Divisor == 0 → BYZERO.
  - Otherwise → ON with `cnt`=0.
  - In signed mode, negate negative operands (two's complement) before loading.
  - Load `dividend_reg`[64:0] = {32'b0, |op1|, 1'b0}.
- **BYZERO**
  - Next edge → END with `result_o`=0, `ready_o`=1.
- **ON** (`annul_i`=1 → FREE, no result)
  - While `cnt` < 32, each edge computes `diff` = `dividend_reg`[63:32] − |divisor| (33-bit).
  - Borrow → shift `dividend_reg` left 1, quotient bit 0.
  - No borrow → `dividend_reg` = {`diff`[31:0], `dividend_reg`[31:0], 1'b1} shifted per restoring algorithm, quotient bit 1.
  - Then `cnt`+1.
  - When `cnt` == 32: apply sign correction and → END.
    - Signed mode: quotient negated if the operand signs differ.
    - Signed mode: remainder negated if the dividend was negative.
    - Register `result_o` = {rem, quot}, `ready_o`=1.
- **END**
  - Hold `result_o` and `ready_o`.
  - When `start_i`=0 → FREE, clearing `ready_o`=0 and `result_o`=0.
- **Input handling**
  - Operand changes after latch are ignored.
  - `start_i` dropping in ON/BYZERO without `annul_i` is ignored; the operation completes.
- **Overflow**: 0x80000000 / 0xFFFFFFFF signed wraps to quot 0x80000000, rem 0; no exception.
- **Arithmetic width**: all magnitude math is unsigned 32-bit, with a 33-bit subtract for borrow detection.

## Timing
- **Reset**: `rst`=1 at an edge → FREE, `cnt`=0, `result_o`=0, `ready_o`=0. This applies in any state, including mid-ON.
- **Normal latency**: `start_i` sampled at edge E0. E1..E32 perform the 32 steps. E33 → END. `ready_o` is high in the cycle after E33, i.e. 33 edges after acceptance.
- **Divide-by-zero latency**: accepted at E0, `ready_o` high after E1.
- **annul_i**
  - Has priority over `start_i` in FREE.
  - Has priority over stepping/completion in ON and BYZERO.
  - In END it is ignored; exit still requires `start_i`=0.
- **Back-to-back operations**: the earliest new acceptance is the edge after END→FREE, since a FREE cycle is mandatory between operations.
- **Result stability**: `ready_o` and `result_o` only change at clock edges; `result_o` is stable for the entire time `ready_o`=1.

## Configuration
- **`DIV_SIGNED_EN` defined**: `signed_div_i` is honored, with operand negation and sign correction as above.
- **`DIV_SIGNED_EN` undefined**
  - `signed_div_i` is ignored; every operation is unsigned, with no negation logic.
  - Divide-by-zero, latency and handshake are identical to the defined case.

## Test plan
- DIVU 100 / 7 → after 33 edges `ready_o`=1, `result_o` = {0x00000002, 0x0000000E}; drop `start_i` → next cycle `ready_o`=0, `result_o`=0.
- DIV −7 / 2 (0xFFFFFFF9, 0x00000002), `DIV_SIGNED_EN` on → `result_o` = {0xFFFFFFFF, 0xFFFFFFFD}. Same stimulus with macro off → {0x00000001, 0x7FFFFFFC}.
- Divisor 0, dividend 0x12345678 → `ready_o`=1 two edges after `start_i` rises, `result_o`=0.
- Start 100/7, assert `annul_i` at E10 → FREE next edge; `ready_o` stays 0 for 40 further cycles with `start_i` low.
- DIV 0x80000000 / 0xFFFFFFFF signed → {0x00000000, 0x80000000}; `rst` asserted at E15 of a second op → `ready_o`=0, `result_o`=0, and a new start is accepted the edge after `rst` deasserts.

Source files
------------

// File: rtl/div_ctrl.sv
// div_ctrl: sequencer for the iterative 32-bit restoring divider used by DIV/DIVU.
// Latches operands on an accepted start, performs one trial subtraction per
// cycle for 32 cycles, then presents {remainder, quotient} with ready_o until
// EX drops start_i. annul_i aborts an operation in flight.
// Optional feature: define DIV_SIGNED_EN to honor signed_div_i (operand
// negation and result sign correction); without it every divide is unsigned.
module div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [5:0]  cnt;
    logic [5:0]  cnt_next;
    logic [64:0] dividend_reg;
    logic [64:0] dividend_next;
    logic [31:0] divisor_reg;
    logic [31:0] divisor_next;
    logic [63:0] result_next;
    logic        ready_next;
    logic [32:0] diff;
    logic [31:0] op1_mag;
    logic [31:0] op2_mag;
    logic [31:0] quot_raw;
    logic [31:0] rem_raw;
    logic [31:0] quot_final;
    logic [31:0] rem_final;
    logic        accept;

    assign accept   = (state == FREE) && start_i && !annul_i;
    assign quot_raw = dividend_reg[31:0];
    assign rem_raw  = dividend_reg[64:33];

`ifdef DIV_SIGNED_EN
    logic op1_neg;
    logic op2_neg;
    logic neg_quot;
    logic neg_rem;

    // Magnitudes of the incoming operands when a signed divide is requested
    always_comb begin
        op1_neg = signed_div_i & opdata1_i[31];
        op2_neg = signed_div_i & opdata2_i[31];
        op1_mag = op1_neg ? (~opdata1_i + 32'd1) : opdata1_i;
        op2_mag = op2_neg ? (~opdata2_i + 32'd1) : opdata2_i;
    end

    // Remember which result halves need negating once the magnitudes are divided
    always_ff @(posedge clk) begin
        if (rst) begin
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
        end else if (accept) begin
            neg_quot <= op1_neg ^ op2_neg;
            neg_rem  <= op1_neg;
        end
    end

    // Restore the signs: quotient follows the sign rule, remainder follows the dividend
    always_comb begin
        quot_final = neg_quot ? (~quot_raw + 32'd1) : quot_raw;
        rem_final  = neg_rem  ? (~rem_raw  + 32'd1) : rem_raw;
    end
`else
    logic unused_signed_div;

    assign unused_signed_div = signed_div_i;

    // Unsigned-only build: operands and results pass straight through
    always_comb begin
        op1_mag    = opdata1_i;
        op2_mag    = opdata2_i;
        quot_final = quot_raw;
        rem_final  = rem_raw;
    end
`endif

    // Trial subtraction of the divisor from the current partial remainder
    assign diff = {1'b0, dividend_reg[63:32]} - {1'b0, divisor_reg};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FREE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath decisions for each FSM state
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        dividend_next = dividend_reg;
        divisor_next  = divisor_reg;
        result_next   = result_o;
        ready_next    = ready_o;
        case (state)
            FREE: begin
                if (accept) begin
                    divisor_next = op2_mag;
                    if (opdata2_i == 32'd0) begin
                        state_next = BYZERO;
                    end else begin
                        state_next    = ON;
                        cnt_next      = 6'd0;
                        dividend_next = {32'd0, op1_mag, 1'b0};
                    end
                end
            end
            BYZERO: begin
                if (annul_i) begin
                    state_next = FREE;
                end else begin
                    state_next  = END;
                    result_next = 64'd0;
                    ready_next  = 1'b1;
                end
            end
            ON: begin
                if (annul_i) begin
                    state_next = FREE;
                    cnt_next   = 6'd0;
                end else if (cnt != 6'd32) begin
                    if (diff[32]) begin
                        dividend_next = {dividend_reg[63:0], 1'b0};
                    end else begin
                        dividend_next = {diff[31:0], dividend_reg[31:0], 1'b1};
                    end
                    cnt_next = cnt + 6'd1;
                end else begin
                    state_next  = END;
                    cnt_next    = 6'd0;
                    result_next = {rem_final, quot_final};
                    ready_next  = 1'b1;
                end
            end
            END: begin
                if (!start_i) begin
                    state_next  = FREE;
                    result_next = 64'd0;
                    ready_next  = 1'b0;
                end
            end
            default: begin
                state_next = FREE;
            end
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= 6'd0;
            dividend_reg <= 65'd0;
            divisor_reg  <= 32'd0;
            result_o     <= 64'd0;
            ready_o      <= 1'b0;
        end else begin
            cnt          <= cnt_next;
            dividend_reg <= dividend_next;
            divisor_reg  <= divisor_next;
            result_o     <= result_next;
            ready_o      <= ready_next;
        end
    end

endmodule
